// File: rtl/clk_downsampler_prog.sv
// Programmable clock downsampler: emits a tick every D+1 cycles and a registered
// divided clock with period 2*(D+1), with a glitch-free stop and tick-aligned reconfiguration.
module clk_downsampler_prog #(
  parameter int WIDTH_P     = 8,
  parameter int RESET_DIV_P = 0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic               cfg_v_i,
  input  logic [WIDTH_P-1:0] cfg_div_i,
  output logic               cfg_ready_o,
  output logic               tick_o,
  output logic               div_clk_o,
  output logic               busy_o,
  output logic [WIDTH_P-1:0] active_div_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [WIDTH_P-1:0] cnt_q, cnt_d;
  logic [WIDTH_P-1:0] div_q, div_d;
  logic [WIDTH_P-1:0] pend_div_q, pend_div_d;
  logic               pend_v_q, pend_v_d;
  logic               div_clk_q, div_clk_d;
  logic               tick;
  logic               accept;
  logic               leave;

  always_comb begin
    tick       = (state_q != IDLE) && (cnt_q == div_q);
    accept     = cfg_v_i && !pend_v_q;
    leave      = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_v_d   = pend_v_q;
    div_clk_d  = div_clk_q;

    if (state_q == IDLE) begin
      cnt_d     = '0;
      div_clk_d = 1'b0;
      if (accept) div_d = cfg_div_i;
      if (en_i) state_d = RUN;
    end else begin
      // Stop now if the output is low, otherwise only at the tick that drops it.
      leave = (state_q == RUN && !en_i && !div_clk_q) ||
              (tick && div_clk_q && (state_q == DRAIN || !en_i));
      if (leave) begin
        state_d   = IDLE;
        cnt_d     = '0;
        div_clk_d = 1'b0;
        pend_v_d  = 1'b0;
        if (accept) div_d = cfg_div_i;
        else if (pend_v_q) div_d = pend_div_q;
      end else begin
        if (state_q == RUN && !en_i) state_d = DRAIN;
        if (tick) begin
          cnt_d     = '0;
          div_clk_d = !div_clk_q;
          if (pend_v_q) begin
            div_d    = pend_div_q;
            pend_v_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + WIDTH_P'(1);
        end
        if (accept) begin
          pend_div_d = cfg_div_i;
          pend_v_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= WIDTH_P'(RESET_DIV_P);
      pend_div_q <= '0;
      pend_v_q   <= 1'b0;
      div_clk_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_v_q   <= pend_v_d;
      div_clk_q  <= div_clk_d;
    end
  end

  assign cfg_ready_o  = !pend_v_q;
  assign tick_o       = tick;
  assign div_clk_o    = div_clk_q;
  assign busy_o       = (state_q != IDLE);
  assign active_div_o = div_q;

endmodule

// File: doc/clk_downsampler_prog.md
CLK_DOWNSAMPLER_PROG -- requirements
Module: clk_downsampler_prog

Interface
REQ-001 Parameter WIDTH_P, default 8: width of the divide value and the internal counter.
REQ-002 Parameter RESET_DIV_P, default 0: divide value loaded at reset.
REQ-003 The block SHALL use one clock, clk_i, and an asynchronous, active-low reset, reset_n_i.
REQ-004 clk_i  input  1  reference clock; all state updates on its rising edge.
REQ-005 reset_n_i  input  1  asynchronous active-low reset.
REQ-006 en_i  input  1  run request; level-sensitive.
REQ-007 cfg_v_i  input  1  new divide value offered.
REQ-008 cfg_div_i  input  WIDTH_P  requested divide value D; output period is 2*(D+1) clk_i cycles.
REQ-009 cfg_ready_o  output  1  block can accept a config this cycle.
REQ-010 tick_o  output  1  one-cycle strobe, once every D+1 cycles while counting.
REQ-011 div_clk_o  output  1  registered divided clock; toggles on each tick.
REQ-012 busy_o  output  1  high when state is not IDLE.
REQ-013 active_div_o  output  WIDTH_P  divide value currently in use (div_r).

Function
REQ-014 State machine SHALL have three states: IDLE, RUN and DRAIN; internal registers are cnt, div_r, pend_v, pend_div and div_clk.
REQ-015 IDLE: cnt=0, div_clk_o=0, tick_o=0; en_i=1 moves the block to RUN on the next edge with cnt=0.
REQ-016 tick_o SHALL be combinational: (state is RUN or DRAIN) and cnt==div_r.
REQ-017 RUN/DRAIN, no tick: cnt increments by 1; cnt never exceeds div_r, so no wrap-around occurs.
REQ-018 On a tick edge: cnt<=0 and div_clk_o toggles, except for the IDLE cases in REQ-020/021.
REQ-019 Timing: first tick in the (div_r+1)th RUN cycle; D=0 gives tick every cycle and div_clk_o = clk_i/2; D=2^WIDTH_P-1 gives period 2^(WIDTH_P+1).
REQ-020 RUN, en_i=0, div_clk_o=0: next state IDLE, cnt<=0, no toggle; the low phase is truncated and no glitch is possible.
REQ-021 RUN, en_i=0, div_clk_o=1: next state DRAIN; on the DRAIN tick div_clk_o goes 0 and the next state is IDLE.
REQ-022 en_i=1 in DRAIN SHALL be ignored; the block reaches IDLE, then re-enters RUN on the following edge if en_i is still 1.
REQ-023 Handshake: cfg_ready_o = !pend_v; a config is accepted when cfg_v_i and cfg_ready_o are both 1.
REQ-024 Accept in IDLE: div_r<=cfg_div_i on the next edge; pend_v stays 0.
REQ-025 Accept in RUN/DRAIN: pend_div<=cfg_div_i, pend_v<=1; no further accept until applied.
REQ-026 Pending config applies only on a tick edge: div_r<=pend_div, pend_v<=0, cnt<=0.
- Result: no partial period ever uses a mixed divide value.
REQ-027 Accept coinciding with a tick: the value goes to pend and applies at the following tick, not the current one.
REQ-028 Pending config when entering IDLE (REQ-020/021): applied on that same edge; pend_v<=0.
REQ-029 busy_o and active_div_o SHALL be direct functions of state and div_r; no added latency.

Reset
REQ-030 While reset_n_i=0 (asynchronous assertion), the block SHALL hold:
- state=IDLE, cnt=0, div_r=RESET_DIV_P, pend_v=0, div_clk_o=0
- tick_o=0, busy_o=0, cfg_ready_o=1, active_div_o=RESET_DIV_P
REQ-031 Reset asserted mid-period SHALL force div_clk_o=0 immediately and discard any pending config.
REQ-032 After deassertion, the first state change SHALL be on the first clk_i edge with reset_n_i=1.

Verification
REQ-033 D=3, en_i held 1 -> tick_o every 4 cycles; div_clk_o period 8 with 4 high / 4 low; first tick in 4th RUN cycle.
REQ-034 D=0 -> tick_o constantly 1 in RUN; div_clk_o toggles every cycle.
REQ-035 Running D=5; cfg D=1 offered mid-period:
- cfg_ready_o drops next cycle
- current period finishes at 6 cycles, then periods of 2
- cfg_ready_o returns 1 after the applying tick
REQ-036 D=4, en_i dropped at cnt=2:
- with div_clk_o=1 -> DRAIN, falls at tick, IDLE, busy_o=0
- with div_clk_o=0 -> IDLE next cycle, no tick
REQ-037 Config offered on a tick cycle is deferred one full period; second cfg_v_i while pending is not accepted (cfg_ready_o=0).
REQ-038 reset_n_i pulsed low mid-high-phase with pending config -> div_clk_o=0 asynchronously, active_div_o=RESET_DIV_P, pend discarded.
